sem_write_arbiter: RTL and testbench

Shares the single semaphore write channel (the inbound FIFO of the byte unit) between N_REQ bit-unit CPU cores. Each core presents a word through a valid/ack handshake. The arbiter grants requesters round-robin and writes one word per grant into the shared FIFO. A requester may lock the channel for an atomic burst of up to MAX_BURST words. The block sits between the cores' sem_data_out/sem_data_valid_out side and the shared FIFO write port.

---
 rtl/sem_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_sem_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sem_write_arbiter.sv
// Round-robin arbiter sharing the semaphore FIFO write port between N_REQ cores,
// with optional per-owner locking for atomic bursts of up to MAX_BURST words.
module sem_write_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 1,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_lock,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ack,
   output logic [DATA_WIDTH-1:0]       fifo_data_out,
   output logic                        fifo_wr_en,
   input  logic                        fifo_full,
   output logic [ID_WIDTH-1:0]         grant_id,
   output logic                        owner_locked
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, XFER, LOCKED} state_t;

   state_t                state, state_nxt;
   logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]      burst_cnt, burst_cnt_nxt;
   logic                  lock_flag, lock_flag_nxt;
   logic [ID_WIDTH-1:0]   grant_nxt;
   logic [ID_WIDTH-1:0]   pick;
   logic [N_REQ-1:0]      ack_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  wr_en_nxt;
   logic                  locked_nxt;

   // First eligible requester scanning upward from ptr, wrapping modulo N_REQ.
   function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [N_REQ-1:0]    elig,
                                                   input logic [ID_WIDTH-1:0] ptr);
      logic [ID_WIDTH-1:0] w;
      logic                found;
      int                  idx;
      w     = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!found && elig[idx]) begin
            w     = idx[ID_WIDTH-1:0];
            found = 1'b1;
         end
      end
      return w;
   endfunction

   function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
      if (int'(id) == N_REQ - 1)
         return '0;
      else
         return id + 1'b1;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] word_of(input logic [N_REQ*DATA_WIDTH-1:0] data,
                                                     input logic [ID_WIDTH-1:0]         id);
      return data[int'(id)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   assign pick = rr_pick(req_valid, rr_ptr);

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      lock_flag_nxt = lock_flag;
      grant_nxt     = grant_id;
      ack_nxt       = '0;
      data_nxt      = '0;
      wr_en_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_full && (|req_valid)) begin
               grant_nxt     = pick;
               data_nxt      = word_of(req_data, pick);
               lock_flag_nxt = req_lock[pick];
               ack_nxt[pick] = 1'b1;
               wr_en_nxt     = 1'b1;
               state_nxt     = XFER;
            end
         end
         XFER: begin
            // The registered strobes are live this cycle; only decide where to go next.
            if (lock_flag && (int'(burst_cnt) + 1 < MAX_BURST)) begin
               burst_cnt_nxt = burst_cnt + 1'b1;
               state_nxt     = LOCKED;
            end else begin
               burst_cnt_nxt = '0;
               rr_ptr_nxt    = next_id(grant_id);
               state_nxt     = IDLE;
            end
         end
         LOCKED: begin
            if (req_valid[grant_id] && !fifo_full) begin
               data_nxt          = word_of(req_data, grant_id);
               lock_flag_nxt     = req_lock[grant_id];
               ack_nxt[grant_id] = 1'b1;
               wr_en_nxt         = 1'b1;
               state_nxt         = XFER;
            end else if (!req_valid[grant_id] && !req_lock[grant_id]) begin
               burst_cnt_nxt = '0;
               rr_ptr_nxt    = next_id(grant_id);
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      locked_nxt = (state_nxt == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         burst_cnt     <= '0;
         lock_flag     <= 1'b0;
         grant_id      <= '0;
         req_ack       <= '0;
         fifo_data_out <= '0;
         fifo_wr_en    <= 1'b0;
         owner_locked  <= 1'b0;
      end else begin
         state         <= state_nxt;
         rr_ptr        <= rr_ptr_nxt;
         burst_cnt     <= burst_cnt_nxt;
         lock_flag     <= lock_flag_nxt;
         grant_id      <= grant_nxt;
         req_ack       <= ack_nxt;
         fifo_data_out <= data_nxt;
         fifo_wr_en    <= wr_en_nxt;
         owner_locked  <= locked_nxt;
      end
   end

   a_ack_onehot : assert property (@(posedge clk) disable iff (rst)
      fifo_wr_en |-> $onehot(req_ack));
   a_burst_bound : assert property (@(posedge clk) disable iff (rst)
      int'(burst_cnt) < MAX_BURST);

endmodule

// File: tb/tb_sem_write_arbiter.sv
// Directed bench for sem_write_arbiter: core models issue words, a monitor scores
// every FIFO write and selected per-cycle status snapshots against queued expectations.
module tb_sem_write_arbiter;

   localparam int N_REQ      = 4;
   localparam int DATA_WIDTH = 1;
   localparam int MAX_BURST  = 4;
   localparam int ID_WIDTH   = 2;
   localparam int MAX_W      = 16;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_lock;
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_ack;
   logic [DATA_WIDTH-1:0]       fifo_data_out;
   logic                        fifo_wr_en;
   logic                        fifo_full;
   logic [ID_WIDTH-1:0]         grant_id;
   logic                        owner_locked;

   sem_write_arbiter #(
      .N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .ID_WIDTH(ID_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
      .req_data(req_data), .req_ack(req_ack), .fifo_data_out(fifo_data_out),
      .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .grant_id(grant_id),
      .owner_locked(owner_locked)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int id; logic [DATA_WIDTH-1:0] data;} wr_exp_t;
   typedef struct {int cyc; int gid; logic locked; logic chk_data;} st_exp_t;

   wr_exp_t wr_q[$];
   st_exp_t st_q[$];

   int   cyc      = 0;
   int   timeouts = 0;
   logic end_req  = 1'b0;
   int   n_chk    = 0;
   int   n_fail   = 0;

   logic [DATA_WIDTH-1:0] wd [N_REQ][MAX_W];
   logic                  wl [N_REQ][MAX_W];
   int                    nw [N_REQ];
   int                    hd [N_REQ];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Core models present their head-of-queue word until acked.
   task automatic drive();
      for (int i = 0; i < N_REQ; i++) begin
         if (hd[i] < nw[i]) begin
            req_valid[i] = 1'b1;
            req_lock[i]  = wl[i][hd[i]];
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = wd[i][hd[i]];
         end else begin
            req_valid[i] = 1'b0;
            req_lock[i]  = 1'b0;
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   endtask

   task automatic clear_cores();
      for (int i = 0; i < N_REQ; i++) begin
         nw[i] = 0;
         hd[i] = 0;
      end
      drive();
   endtask

   task automatic load(input int core, input logic [DATA_WIDTH-1:0] d, input logic l);
      wd[core][nw[core]] = d;
      wl[core][nw[core]] = l;
      nw[core]++;
      drive();
   endtask

   task automatic step();
      logic [N_REQ-1:0] a;
      a = req_ack;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N_REQ; i++)
         if (a[i] === 1'b1 && hd[i] < nw[i]) hd[i]++;
      drive();
   endtask

   function automatic logic cores_idle();
      logic r;
      r = 1'b1;
      for (int i = 0; i < N_REQ; i++)
         if (hd[i] < nw[i]) r = 1'b0;
      return r;
   endfunction

   task automatic exp_wr(input int c, input int id, input logic [DATA_WIDTH-1:0] d);
      wr_exp_t e;
      e.cyc = c; e.id = id; e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic exp_st(input int c, input int gid, input logic locked, input logic chk_data);
      st_exp_t e;
      e.cyc = c; e.gid = gid; e.locked = locked; e.chk_data = chk_data;
      st_q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((wr_q.size() != 0 || st_q.size() != 0 || !cores_idle()) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) timeouts++;
      step();
      step();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      step();
      step();
      exp_st(cyc, 0, 1'b0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin : monitor
      wr_exp_t w;
      st_exp_t s;
      forever begin
         @(negedge clk);
         if (end_req) begin
            chk("pending_writes", wr_q.size(), 0);
            chk("pending_status", st_q.size(), 0);
            chk("wait_timeouts", timeouts, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
         if (fifo_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_write_cycle", cyc, -1);
            end else begin
               w = wr_q.pop_front();
               chk("write_cycle", cyc, w.cyc);
               chk("write_grant_id", int'(grant_id), w.id);
               chk("write_data", int'(fifo_data_out), int'(w.data));
               chk("write_ack", int'(req_ack), 1 << w.id);
               chk("write_owner_locked", int'(owner_locked), 0);
            end
         end else if (req_ack !== '0) begin
            chk("ack_without_write", int'(req_ack), 0);
         end
         while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            s = st_q.pop_front();
            chk("status_cycle", cyc, s.cyc);
            chk("status_wr_en", int'(fifo_wr_en), 0);
            chk("status_ack", int'(req_ack), 0);
            chk("status_grant_id", int'(grant_id), s.gid);
            chk("status_owner_locked", int'(owner_locked), int'(s.locked));
            if (s.chk_data) chk("status_data", int'(fifo_data_out), 0);
         end
      end
   end

   initial begin : stim
      int k;
      rst       = 1'b1;
      fifo_full = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      req_data  = '0;
      clear_cores();
      reset_dut();

      // single request from core 0
      k = cyc;
      load(0, 1'b1, 1'b0);
      exp_wr(k + 1, 0, 1'b1);
      exp_st(k + 2, 0, 1'b0, 1'b0);
      drain();

      // all cores valid, no lock: round-robin 0,1,2,3,0
      reset_dut();
      k = cyc;
      load(0, 1'b1, 1'b0); load(0, 1'b1, 1'b0);
      load(1, 1'b0, 1'b0);
      load(2, 1'b1, 1'b0);
      load(3, 1'b0, 1'b0);
      exp_wr(k + 1, 0, 1'b1); exp_wr(k + 3, 1, 1'b0); exp_wr(k + 5, 2, 1'b1);
      exp_wr(k + 7, 3, 1'b0); exp_wr(k + 9, 0, 1'b1);
      drain();

      // core 2 locked burst of 6 words, forced release after MAX_BURST
      reset_dut();
      k = cyc;
      load(1, 1'b0, 1'b0);
      exp_wr(k + 1, 1, 1'b0);
      step();
      load(2, 1'b1, 1'b1); load(2, 1'b0, 1'b1); load(2, 1'b1, 1'b1);
      load(2, 1'b1, 1'b1); load(2, 1'b0, 1'b1); load(2, 1'b1, 1'b1);
      load(0, 1'b1, 1'b0);
      exp_wr(k + 3, 2, 1'b1);  exp_wr(k + 5, 2, 1'b0);  exp_wr(k + 7, 2, 1'b1);
      exp_wr(k + 9, 2, 1'b1);  exp_wr(k + 11, 0, 1'b1); exp_wr(k + 13, 2, 1'b0);
      exp_wr(k + 15, 2, 1'b1);
      exp_st(k + 4, 2, 1'b1, 1'b0);  exp_st(k + 8, 2, 1'b1, 1'b0);
      exp_st(k + 10, 2, 1'b0, 1'b0); exp_st(k + 16, 2, 1'b1, 1'b0);
      exp_st(k + 17, 2, 1'b0, 1'b0);
      drain();

      // FIFO full holds off core 2 for five cycles
      reset_dut();
      k = cyc;
      fifo_full = 1'b1;
      load(2, 1'b1, 1'b0);
      exp_st(k + 3, 0, 1'b0, 1'b0);
      exp_st(k + 5, 0, 1'b0, 1'b0);
      exp_wr(k + 6, 2, 1'b1);
      repeat (5) step();
      fifo_full = 1'b0;
      drain();

      // core 1 locks for two words then releases; core 3 beats core 0
      reset_dut();
      k = cyc;
      load(1, 1'b1, 1'b1); load(1, 1'b0, 1'b1);
      exp_wr(k + 1, 1, 1'b1); exp_wr(k + 3, 1, 1'b0);
      step();
      load(3, 1'b1, 1'b0);
      load(0, 1'b0, 1'b0);
      exp_wr(k + 6, 3, 1'b1); exp_wr(k + 8, 0, 1'b0);
      exp_st(k + 2, 1, 1'b1, 1'b0); exp_st(k + 4, 1, 1'b1, 1'b0);
      exp_st(k + 5, 1, 1'b0, 1'b0);
      drain();

      // reset while core 3 holds the lock
      reset_dut();
      k = cyc;
      load(3, 1'b1, 1'b1); load(3, 1'b1, 1'b1); load(3, 1'b0, 1'b1);
      exp_wr(k + 1, 3, 1'b1); exp_wr(k + 3, 3, 1'b1);
      exp_st(k + 4, 3, 1'b1, 1'b0);
      repeat (4) step();
      rst = 1'b1;
      clear_cores();
      load(0, 1'b1, 1'b0); load(1, 1'b0, 1'b0); load(2, 1'b1, 1'b0); load(3, 1'b1, 1'b0);
      step();
      exp_st(cyc, 0, 1'b0, 1'b1);
      rst = 1'b0;
      exp_wr(k + 6, 0, 1'b1); exp_wr(k + 8, 1, 1'b0);
      exp_wr(k + 10, 2, 1'b1); exp_wr(k + 12, 3, 1'b1);
      drain();

      end_req = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL monitor_end: got no summary, expected summary");
      $fatal(1, "monitor did not terminate");
   end

endmodule
